// File: rtl/digital_lock_pkg.sv
// rtl/digital_lock_pkg.sv - shared state encoding and default constants for digital_lock_seq
package digital_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_t;

  localparam int         FAIL_W             = 4;
  localparam int         DEF_CODE_LEN       = 4;
  localparam logic [3:0] DEF_CODE           = 4'b1101;
  localparam int         DEF_MAX_FAIL       = 3;
  localparam int         DEF_LOCKOUT_CYCLES = 8;

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with a done flag, times the lockout window
module lock_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // load wins over decrement; the counter parks at zero until reloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/digital_lock_seq.sv
// rtl/digital_lock_seq.sv - serial code lock with fail counting and timed lockout (option: DIGITAL_LOCK_PROG_EN)
module digital_lock_seq
  import digital_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE           = CODE_LEN'(DEF_CODE),
  parameter int                  MAX_FAIL       = DEF_MAX_FAIL,
  parameter int                  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              abort,
  input  logic              relock,
`ifdef DIGITAL_LOCK_PROG_EN
  input  logic              prog_valid,
  input  logic [CODE_LEN-1:0] prog_code,
`endif
  output logic              unlock,
  output logic              fail_pulse,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0]     LAST_BIT = CW'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
  localparam logic [TW-1:0]     TMR_LOAD = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t         state;
  logic [CODE_LEN-2:0] shift_q;
  logic [CW-1:0]       bit_cnt;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] attempt;
  logic [FAIL_W-1:0]   fail_next;
  logic                last_bit;
  logic                match;
  logic                goto_lock;
  logic                tmr_done;

`ifdef DIGITAL_LOCK_PROG_EN
  // the programmed code only changes while the lock is open
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= CODE;
    end else if ((state == ST_OPEN) && prog_valid) begin
      code_q <= prog_code;
    end
  end
`else
  assign code_q = CODE;
`endif

  // attempt decode: the incoming bit completes the word without waiting a cycle
  always_comb begin
    attempt   = {shift_q, in_bit};
    last_bit  = (state == ST_ENTRY) && in_valid && !abort && (bit_cnt == LAST_BIT);
    match     = (attempt == code_q);
    fail_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
    goto_lock = last_bit && !match && (fail_next == FAIL_MAX);
  end

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (goto_lock),
    .en       (state == ST_LOCKOUT),
    .load_val (TMR_LOAD),
    .done     (tmr_done)
  );

  // main lock FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_ENTRY;
      shift_q    <= '0;
      bit_cnt    <= '0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      fail_pulse <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (abort) begin
            bit_cnt <= '0;
            shift_q <= '0;
          end else if (in_valid) begin
            shift_q <= attempt[CODE_LEN-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (match) begin
                state    <= ST_OPEN;
                unlock   <= 1'b1;
                fail_cnt <= '0;
              end else begin
                fail_pulse <= 1'b1;
                fail_cnt   <= fail_next;
                if (fail_next == FAIL_MAX) begin
                  state   <= ST_LOCKOUT;
                  lockout <= 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_OPEN: begin
          if (relock) begin
            state   <= ST_ENTRY;
            unlock  <= 1'b0;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        ST_LOCKOUT: begin
          if (tmr_done) begin
            state    <= ST_ENTRY;
            lockout  <= 1'b0;
            fail_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_ENTRY;
          unlock  <= 1'b0;
          lockout <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digital_lock_seq.sv
// tb/tb_digital_lock_seq.sv - directed vector bench for digital_lock_seq (option: DIGITAL_LOCK_PROG_EN)
module tb_digital_lock_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic       relock = 1'b0;
  logic       unlock;
  logic       fail_pulse;
  logic       lockout;
  logic [3:0] fail_cnt;
`ifdef DIGITAL_LOCK_PROG_EN
  logic       prog_valid = 1'b0;
  logic [3:0] prog_code = 4'b0000;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  digital_lock_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .abort      (abort),
    .relock     (relock),
`ifdef DIGITAL_LOCK_PROG_EN
    .prog_valid (prog_valid),
    .prog_code  (prog_code),
`endif
    .unlock     (unlock),
    .fail_pulse (fail_pulse),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  typedef struct packed {
    logic       b, v, a, r;
    logic       eu, ef, el;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] bvar, input logic [2:0] ufl, input logic [3:0] c);
    vec_t t;
    {t.b, t.v, t.a, t.r} = bvar;
    {t.eu, t.ef, t.el}   = ufl;
    t.ec                 = c;
    return t;
  endfunction

  function automatic logic [6:0] obs();
    return {unlock, fail_pulse, lockout, fail_cnt};
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: unlock/fail_pulse/lockout/fail_cnt got %b_%b_%b_%0d required %b_%b_%b_%0d",
               nm, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic a, input logic r);
    @(negedge clk);
    in_bit = b; in_valid = v; abort = a; relock = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) step(c[i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int         lock_cycles;
    int         pulses;
    logic [3:0] pat;

    // test 1: correct code, ignored bits while open, relock
    tbl.push_back(mk(4'b1100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b1100, 3'b100, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b100, 4'd0));
    tbl.push_back(mk(4'b0001, 3'b000, 4'd0));
    // test 2: unqualified bit, wrong attempt 1010, then correct code
    tbl.push_back(mk(4'b1000, 3'b000, 4'd0));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b010, 4'd1));
    tbl.push_back(mk(4'b0000, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b100, 4'd0));
    tbl.push_back(mk(4'b0001, 3'b000, 4'd0));
    // test 4: one failure, relock in ENTRY, partial entry aborted with in_valid high
    tbl.push_back(mk(4'b0100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd0));
    tbl.push_back(mk(4'b0100, 3'b010, 4'd1));
    tbl.push_back(mk(4'b0001, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1110, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b0100, 3'b000, 4'd1));
    tbl.push_back(mk(4'b1100, 3'b100, 4'd0));
    tbl.push_back(mk(4'b0001, 3'b000, 4'd0));

    #1;
    check("reset_state", obs(), 7'b0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].v, tbl[i].a, tbl[i].r);
      check($sformatf("vec[%0d]", i), obs(), {tbl[i].eu, tbl[i].ef, tbl[i].el, tbl[i].ec});
    end
    @(negedge clk);
    in_valid = 1'b0; relock = 1'b0; abort = 1'b0;

    // test 3: three failures, lockout window with 1101 fed throughout
    send_code(4'b0000);
    send_code(4'b0000);
    check("second_fail_cnt", {1'b0, 2'b00, fail_cnt}, 7'd2);
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("lockout_entry", obs(), {3'b011, 4'd3});
    pat = 4'b1101;
    lock_cycles = 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(pat[3 - (i % 4)], 1'b1, (i == 2), (i == 5));
      if (!lockout) break;
      lock_cycles++;
      if (fail_pulse || unlock) pulses++;
    end
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0; relock = 1'b0;
    check("lockout_length", 7'(lock_cycles), 7'd8);
    check("lockout_ignored_input", 7'(pulses), 7'd0);
    check("after_lockout", obs(), 7'b0);
    send_code(4'b1101);
    check("unlock_after_lockout", obs(), {3'b100, 4'd0});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("relock_after_lockout", obs(), 7'b0);
    @(negedge clk);
    relock = 1'b0;

    // test 5: asynchronous reset on the 4th cycle of lockout
    send_code(4'b0000);
    send_code(4'b0000);
    send_code(4'b0000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_lockout", obs(), {3'b001, 4'd3});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", obs(), 7'b0);
    @(negedge clk);
    reset = 1'b1;
    send_code(4'b1101);
    check("unlock_after_reset", obs(), {3'b100, 4'd0});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    relock = 1'b0;

`ifdef DIGITAL_LOCK_PROG_EN
    // test 6: program 0110 while open, old code then fails, new code opens
    send_code(4'b1101);
    @(negedge clk);
    prog_code = 4'b0110; prog_valid = 1'b1;
    @(negedge clk);
    prog_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    relock = 1'b0;
    for (int i = 3; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
    check("prog_old_code_fails", obs(), {3'b010, 4'd1});
    send_code(4'b0110);
    check("prog_new_code_opens", obs(), {3'b100, 4'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
